// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants, types and width helpers for the host-port
// receiver (io_port_rx) and its word FIFO (io_port_fifo).
//
// Contents:
//   BYTE_W        width of one link byte (8)
//   asm_state_t   assembler state: ST_EMPTY (no bytes held), ST_FILLING
//   entry_tag_t   per-entry tag (partial flag), only with IO_PORT_RX_TIMEOUT_EN
//   TAG_W         number of tag bits stored alongside each FIFO word
//   idx_width()   width of the byte index for a given word size
//   level_width() width of the FIFO occupancy count for a given depth
//   entry_width() total FIFO entry width (data plus optional tag)
//
// Optional feature macro: IO_PORT_RX_TIMEOUT_EN adds the partial tag bit.
package io_port_pkg;

  localparam int BYTE_W = 8;

`ifdef IO_PORT_RX_TIMEOUT_EN
  typedef struct packed {
    logic partial;
  } entry_tag_t;
  localparam int TAG_W = $bits(entry_tag_t);
`else
  localparam int TAG_W = 0;
`endif

  typedef enum logic {
    ST_EMPTY,
    ST_FILLING
  } asm_state_t;

  // A single-byte word still needs a 1-bit index register.
  function automatic int idx_width(input int width_bytes);
    return (width_bytes > 1) ? $clog2(width_bytes) : 1;
  endfunction

  // One extra bit so that a completely full FIFO (level == depth) fits.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int entry_width(input int width_bytes);
    return width_bytes * BYTE_W + TAG_W;
  endfunction

endpackage

// File: rtl/io_port_fifo.sv
// io_port_fifo: synchronous circular-buffer FIFO.
//
// Parameters:
//   ENTRY_W   width of one stored entry
//   DEPTH     number of entries, power of two, at least 2
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   push, push_data       write an entry (ignored when full)
//   pop                   drop the head entry (ignored when empty)
//   pop_data              head entry, zero while empty
//   full, empty, level    occupancy status derived from the level counter
module io_port_fifo
  import io_port_pkg::*;
#(
  parameter int ENTRY_W = 33,
  parameter int DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [ENTRY_W-1:0]            push_data,
  input  logic                          pop,
  output logic [ENTRY_W-1:0]            pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_width(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Pointers alone cannot tell full from empty, so both come from level.
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !rst;
  assign do_pop  = pop && !empty;

  // Storage has no reset; stale entries are never visible because the
  // head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + LVL_W'(1);
      end else if (do_pop && !do_push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/io_port_rx.sv
// io_port_rx: host-port receiver. Packs a valid/ready byte stream into
// WIDTH_BYTES-byte words and buffers them in a DEPTH-entry FIFO that drains
// on a valid/ready handshake.
//
// Parameters:
//   WIDTH_BYTES     bytes per word (>= 1)
//   DEPTH           FIFO depth in words (power of two, >= 2)
//   BIG_ENDIAN      1: first byte lands in the top lane; 0: in bits [7:0]
//   TIMEOUT_CYCLES  idle cycles before a partial word is flushed out
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_data, in_valid, in_ready     byte input handshake
//   flush                           drop the partially assembled word
//   out_data, out_valid, out_ready  word output handshake (FIFO head)
//   out_partial                     head word was timeout-padded
//   level                           FIFO occupancy in words
//
// Optional feature macro: IO_PORT_RX_TIMEOUT_EN enables the idle timeout,
// the per-entry partial tag and the out_partial port.
module io_port_rx
  import io_port_pkg::*;
#(
  parameter int WIDTH_BYTES    = 4,
  parameter int DEPTH          = 8,
  parameter int BIG_ENDIAN     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [BYTE_W-1:0]                 in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              flush,
  output logic [WIDTH_BYTES*BYTE_W-1:0]     out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
`ifdef IO_PORT_RX_TIMEOUT_EN
  output logic                              out_partial,
`endif
  output logic [level_width(DEPTH)-1:0]     level
);

  localparam int WORD_W  = WIDTH_BYTES * BYTE_W;
  localparam int IDX_W   = idx_width(WIDTH_BYTES);
  localparam int ENTRY_W = entry_width(WIDTH_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH_BYTES - 1);

  // Reject illegal configurations at elaboration time.
  if (WIDTH_BYTES < 1) begin : g_bad_width
    $error("io_port_rx: WIDTH_BYTES must be at least 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("io_port_rx: DEPTH must be a power of two, at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("io_port_rx: TIMEOUT_CYCLES must be at least 1");
  end

  asm_state_t         state;
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  word_q;
  logic [WORD_W-1:0]  word_with_byte;
  logic [IDX_W-1:0]   lane;
  logic               accept;
  logic               push_word;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  // A completing byte is refused only when its word has nowhere to go;
  // out_ready is deliberately left out so no combinational path exists.
  assign in_ready  = (idx != LAST_IDX) || !fifo_full;
  assign accept    = in_valid && in_ready;
  assign push_word = accept && (idx == LAST_IDX) && !flush;
  assign fifo_pop  = out_ready && !fifo_empty;
  assign out_valid = !fifo_empty;

  // Merge the incoming byte into its lane; lane order follows BIG_ENDIAN.
  // An EMPTY assembler always starts from a clean word.
  always_comb begin
    lane           = (BIG_ENDIAN != 0) ? (LAST_IDX - idx) : idx;
    word_with_byte = (state == ST_EMPTY) ? '0 : word_q;
    word_with_byte[lane*BYTE_W +: BYTE_W] = in_data;
  end

`ifdef IO_PORT_RX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             timeout_fire;
  entry_tag_t       push_tag;
  entry_tag_t       head_tag;

  // A real byte or a flush always wins over the timeout; a full FIFO
  // simply postpones it.
  assign timeout_fire = (state == ST_FILLING) && (idle_cnt == CNT_W'(TIMEOUT_CYCLES))
                        && !fifo_full && !accept && !flush;

  // Idle counter saturates at TIMEOUT_CYCLES and only runs mid-word.
  always_ff @(posedge clk) begin
    if (rst || flush || accept || timeout_fire || state == ST_EMPTY) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // Padded lanes are already zero in word_q, so it is pushed as-is.
  always_comb begin
    push_tag.partial = timeout_fire;
  end
  assign fifo_push   = push_word || timeout_fire;
  assign push_entry  = timeout_fire ? {word_q, push_tag} : {word_with_byte, push_tag};
  assign out_data    = head_entry[ENTRY_W-1:TAG_W];
  assign head_tag    = head_entry[TAG_W-1:0];
  assign out_partial = head_tag.partial;
`else
  assign fifo_push  = push_word;
  assign push_entry = word_with_byte;
  assign out_data   = head_entry;
`endif

  // Assembler FSM: flush beats a same-cycle byte, and a pushed word leaves
  // the word register cleared so unused lanes start at zero.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= ST_EMPTY;
      idx    <= '0;
      word_q <= '0;
    end else if (accept) begin
      if (idx == LAST_IDX) begin
        state  <= ST_EMPTY;
        idx    <= '0;
        word_q <= '0;
      end else begin
        state  <= ST_FILLING;
        idx    <= idx + IDX_W'(1);
        word_q <= word_with_byte;
      end
`ifdef IO_PORT_RX_TIMEOUT_EN
    end else if (timeout_fire) begin
      state  <= ST_EMPTY;
      idx    <= '0;
      word_q <= '0;
`endif
    end
  end

  io_port_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

endmodule

// File: tb/tb_io_port_rx.sv
// tb_io_port_rx: bench for io_port_rx. Two instances share every input:
// one packs big-endian, the other little-endian. A queue-based model of the
// byte stream predicts handshakes, occupancy and word contents each cycle.
// With IO_PORT_RX_TIMEOUT_EN defined the idle-timeout path is covered too.
module tb_io_port_rx;

  localparam int WB    = 4;
  localparam int DEPTH = 8;
  localparam int TO    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready_be, in_ready_le;
  logic        out_valid_be, out_valid_le;
  logic [31:0] out_data_be, out_data_le;
  logic [3:0]  level_be, level_le;
`ifdef IO_PORT_RX_TIMEOUT_EN
  logic        out_partial_be, out_partial_le;
`endif

  always #5 clk = ~clk;

  io_port_rx #(.WIDTH_BYTES(WB), .DEPTH(DEPTH), .BIG_ENDIAN(1), .TIMEOUT_CYCLES(TO)) dut_be (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_be),
    .flush(flush), .out_data(out_data_be), .out_valid(out_valid_be), .out_ready(out_ready),
`ifdef IO_PORT_RX_TIMEOUT_EN
    .out_partial(out_partial_be),
`endif
    .level(level_be));

  io_port_rx #(.WIDTH_BYTES(WB), .DEPTH(DEPTH), .BIG_ENDIAN(0), .TIMEOUT_CYCLES(TO)) dut_le (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_le),
    .flush(flush), .out_data(out_data_le), .out_valid(out_valid_le), .out_ready(out_ready),
`ifdef IO_PORT_RX_TIMEOUT_EN
    .out_partial(out_partial_le),
`endif
    .level(level_le));

  int compared   = 0;
  int mismatched = 0;
  bit expect_zero_data = 1'b0;

  // Reference model: bytes of the word being assembled, and the queued words.
  logic [7:0]  partial_bytes[$];
  logic [31:0] exp_be[$];
  logic [31:0] exp_le[$];
  bit          exp_tag[$];
  int          idle_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit expReady();
    return (partial_bytes.size() != WB - 1) || (exp_be.size() != DEPTH);
  endfunction

  // Turn the held bytes (zero-padded) into both byte orders and queue them.
  task automatic pushModelWord(input bit tag);
    logic [31:0] be = 32'h0;
    logic [31:0] le = 32'h0;
    for (int i = 0; i < WB; i++) begin
      logic [7:0] b;
      b  = (i < partial_bytes.size()) ? partial_bytes[i] : 8'h00;
      be = be | (32'(b) << (8 * (WB - 1 - i)));
      le = le | (32'(b) << (8 * i));
    end
    exp_be.push_back(be);
    exp_le.push_back(le);
    exp_tag.push_back(tag);
    partial_bytes.delete();
  endtask

  task automatic checkModel();
    checkOutput("in_ready_be", 32'(in_ready_be), 32'(expReady()));
    checkOutput("in_ready_le", 32'(in_ready_le), 32'(expReady()));
    checkOutput("out_valid_be", 32'(out_valid_be), 32'(exp_be.size() != 0));
    checkOutput("out_valid_le", 32'(out_valid_le), 32'(exp_le.size() != 0));
    checkOutput("level_be", 32'(level_be), 32'(exp_be.size()));
    checkOutput("level_le", 32'(level_le), 32'(exp_le.size()));
    if (exp_be.size() != 0) begin
      checkOutput("head_be", out_data_be, exp_be[0]);
      checkOutput("head_le", out_data_le, exp_le[0]);
`ifdef IO_PORT_RX_TIMEOUT_EN
      checkOutput("partial_be", 32'(out_partial_be), 32'(exp_tag[0]));
      checkOutput("partial_le", 32'(out_partial_le), 32'(exp_tag[0]));
`endif
    end
    if (expect_zero_data) begin
      checkOutput("reset_data_be", out_data_be, 32'h0);
      checkOutput("reset_data_le", out_data_le, 32'h0);
`ifdef IO_PORT_RX_TIMEOUT_EN
      checkOutput("reset_partial", 32'(out_partial_be), 32'h0);
`endif
    end
  endtask

  // Advance the model across one clock edge from the current inputs.
  task automatic modelStep(input bit rst_i, input bit valid_i, input logic [7:0] data_i,
                           input bit flush_i, input bit ready_i);
    bit accept, do_pop, fire, was_filling;
    if (rst_i) begin
      partial_bytes.delete();
      exp_be.delete();
      exp_le.delete();
      exp_tag.delete();
      idle_count = 0;
      return;
    end
    accept      = valid_i && expReady();
    do_pop      = ready_i && (exp_be.size() != 0);
    was_filling = (partial_bytes.size() != 0);
    fire        = 1'b0;
`ifdef IO_PORT_RX_TIMEOUT_EN
    fire = was_filling && (idle_count == TO) && !accept && !flush_i && (exp_be.size() != DEPTH);
`endif
    if (do_pop) begin
      void'(exp_be.pop_front());
      void'(exp_le.pop_front());
      void'(exp_tag.pop_front());
    end
    if (flush_i) begin
      partial_bytes.delete();
    end else if (accept) begin
      partial_bytes.push_back(data_i);
      if (partial_bytes.size() == WB) pushModelWord(1'b0);
    end else if (fire) begin
      pushModelWord(1'b1);
    end
    if (!was_filling || accept || flush_i || fire) idle_count = 0;
    else if (idle_count < TO) idle_count++;
  endtask

  // One cycle: check outputs on the falling edge, then drive the next inputs.
  task automatic applyStimulus(input bit rst_i, input bit valid_i, input logic [7:0] data_i,
                               input bit flush_i, input bit ready_i);
    @(negedge clk);
    checkModel();
    rst       = rst_i;
    in_valid  = valid_i;
    in_data   = data_i;
    flush     = flush_i;
    out_ready = ready_i;
    modelStep(rst_i, valid_i, data_i, flush_i, ready_i);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit ready_i);
    applyStimulus(1'b0, 1'b1, b, 1'b0, ready_i);
  endtask

  task automatic idleCycles(input int n, input bit ready_i);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, ready_i);
  endtask

  initial begin
    logic [7:0] seq_a[4];
    seq_a = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset, then confirm reset values.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1);
    expect_zero_data = 1'b1;
    idleCycles(1, 1'b0);
    expect_zero_data = 1'b0;

    // Basic word in both byte orders.
    for (int i = 0; i < 4; i++) sendByte(seq_a[i], 1'b0);
    idleCycles(1, 1'b0);
    checkOutput("word_be_11223344", out_data_be, 32'h11223344);
    checkOutput("word_le_44332211", out_data_le, 32'h44332211);
    checkOutput("word_level_1", 32'(level_be), 32'd1);
    idleCycles(2, 1'b1);

    // Backpressure: fill all 8 entries, then 3 bytes, then a stalled 4th.
    for (int i = 0; i < 8 * WB + 3; i++) sendByte(8'($urandom), 1'b0);
    sendByte(8'hE4, 1'b0);
    checkOutput("full_level", 32'(level_be), 32'd8);
    checkOutput("full_in_ready", 32'(in_ready_be), 32'd0);
    sendByte(8'hE4, 1'b1);
    sendByte(8'hE4, 1'b0);
    idleCycles(1, 1'b0);
    checkOutput("refill_level", 32'(level_be), 32'd8);
    idleCycles(12, 1'b1);

    // Flush drops the partial word and a same-cycle byte.
    sendByte(8'hAA, 1'b0);
    sendByte(8'hBB, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) sendByte(8'(i), 1'b0);
    idleCycles(1, 1'b0);
    checkOutput("flush_word", out_data_be, 32'h01020304);
    idleCycles(3, 1'b1);

`ifdef IO_PORT_RX_TIMEOUT_EN
    // Idle timeout pushes a padded, tagged word; the next word is untagged.
    sendByte(8'hC0, 1'b0);
    sendByte(8'hFF, 1'b0);
    idleCycles(TO + 2, 1'b0);
    checkOutput("timeout_word", out_data_be, 32'hC0FF0000);
    checkOutput("timeout_tag", 32'(out_partial_be), 32'd1);
    for (int i = 0; i < 4; i++) sendByte(8'($urandom), 1'b0);
    idleCycles(4, 1'b1);
`endif

    // Reset with level=3 and idx=2 discards everything.
    for (int i = 0; i < 3 * WB + 2; i++) sendByte(8'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    expect_zero_data = 1'b1;
    sendByte(8'h5A, 1'b0);
    expect_zero_data = 1'b0;
    sendByte(8'h6B, 1'b0);
    sendByte(8'h7C, 1'b0);
    sendByte(8'h8D, 1'b0);
    idleCycles(1, 1'b0);
    checkOutput("post_reset_word", out_data_be, 32'h5A6B7C8D);
    checkOutput("post_reset_level", 32'(level_be), 32'd1);

    // Random traffic alternating slow and fast drain to reach full and empty.
    for (int c = 0; c < 3000; c++) begin
      int ready_pct;
      ready_pct = ((c / 300) % 2 == 1) ? 85 : 20;
      applyStimulus($urandom_range(999) < 2, $urandom_range(99) < 70, 8'($urandom),
                    $urandom_range(99) < 3, $urandom_range(99) < ready_pct);
    end
    idleCycles(20, 1'b1);
    @(negedge clk);
    checkModel();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
